// File: rtl/meas_sequencer.sv
// rtl/meas_sequencer.sv - round-robin measurement scheduler with tagged result FIFO
// Issues enabled command-table slots to the acquisition core and queues {slot, timeout, result}.
module meas_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int INTERVAL_W     = 24
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        SeqEnable,
  input  logic [7:0]                  SlotMask,
  input  logic [INTERVAL_W-1:0]       IntervalCycles,
  input  logic                        CfgWe,
  input  logic [2:0]                  CfgAddr,
  input  logic [31:0]                 CfgData,
  output logic [31:0]                 CmdOut,
  output logic                        ClearOut,
  output logic                        CoreEn,
  input  logic [2:0]                  CoreStatus,
  input  logic [31:0]                 CoreResult,
  input  logic                        RdEn,
  output logic [35:0]                 RdData,
  output logic                        Empty,
  output logic                        Full,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Overflow,
  output logic                        TimeoutSticky,
  input  logic                        StickyClear,
  output logic                        SeqBusy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, CLEAR, SETTLE, INTERVAL} state_t;

  state_t                state, state_d, adv_state;
  logic [2:0]            slot, slot_d, adv_slot;
  logic                  adv_load;
  logic [15:0]           timer, timer_d;
  logic [INTERVAL_W-1:0] ival_cnt, ival_d;
  logic [31:0]           slot_table [8];
  logic                  en_q;

  logic [2:0]            low_idx, next_idx;
  logic                  next_found;
  logic                  push, push_to;
  logic [35:0]           push_data;

  logic [35:0]           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count_q;
  logic                  fifo_full, fifo_empty, do_push, do_pop;
  logic                  unused_status;

  assign unused_status = ^CoreStatus[2:1];

  // Slot selection and end-of-step decision shared by SETTLE and a skipped ISSUE
  always_comb begin
    low_idx    = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (SlotMask[i]) low_idx = 3'(i);
      if (SlotMask[i] && (i > int'(slot))) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
    adv_state = IDLE;
    adv_slot  = slot;
    adv_load  = 1'b0;
    if (!SeqEnable || SlotMask == 8'h00) begin
      adv_state = IDLE;
    end else if (next_found) begin
      adv_state = ISSUE;
      adv_slot  = next_idx;
    end else if (IntervalCycles == '0) begin
      adv_state = ISSUE;
      adv_slot  = low_idx;
    end else begin
      adv_state = INTERVAL;
      adv_load  = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    slot_d  = slot;
    timer_d = timer;
    ival_d  = ival_cnt;
    push    = 1'b0;
    push_to = 1'b0;
    case (state)
      IDLE: begin
        if (SeqEnable && SlotMask != 8'h00) begin
          state_d = ISSUE;
          slot_d  = low_idx;
        end
      end
      ISSUE: begin
        if (slot_table[slot] == 32'h0) begin
          state_d = adv_state;
          slot_d  = adv_slot;
          if (adv_load) ival_d = IntervalCycles;
        end else begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        timer_d = timer + 16'd1;
        if (CoreStatus[0]) begin
          push    = 1'b1;
          state_d = CLEAR;
        end else if (timer == TIMER_LAST) begin
          push    = 1'b1;
          push_to = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT:  state_d = SETTLE;
      CLEAR:  state_d = SETTLE;
      SETTLE: begin
        state_d = adv_state;
        slot_d  = adv_slot;
        if (adv_load) ival_d = IntervalCycles;
      end
      INTERVAL: begin
        if (!SeqEnable || SlotMask == 8'h00) begin
          state_d = IDLE;
        end else if (ival_cnt <= INTERVAL_W'(1)) begin
          state_d = ISSUE;
          slot_d  = low_idx;
        end else begin
          ival_d = ival_cnt - INTERVAL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      slot     <= '0;
      timer    <= '0;
      ival_cnt <= '0;
      en_q     <= 1'b0;
      for (int i = 0; i < 8; i++) slot_table[i] <= '0;
    end else begin
      state    <= state_d;
      slot     <= slot_d;
      timer    <= timer_d;
      ival_cnt <= ival_d;
      en_q     <= 1'b1;
      if (CfgWe) slot_table[CfgAddr] <= CfgData;
    end
  end

  // A timed-out slot carries a zero result so software never sees stale core data
  assign push_data  = {slot, push_to, push_to ? 32'h0 : CoreResult};
  assign fifo_full  = (count_q == DEPTH_V);
  assign fifo_empty = (count_q == '0);
  assign do_pop     = RdEn && !fifo_empty;
  assign do_push    = push && (!fifo_full || do_pop);

  always_ff @(posedge Clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      Overflow      <= 1'b0;
      TimeoutSticky <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (StickyClear) begin
        Overflow      <= 1'b0;
        TimeoutSticky <= 1'b0;
      end else begin
        if (push && fifo_full && !do_pop) Overflow <= 1'b1;
        if (push && push_to) TimeoutSticky <= 1'b1;
      end
    end
  end

  assign CmdOut   = (state == ISSUE) ? slot_table[slot] : 32'h0;
  assign ClearOut = (state == CLEAR);
  assign CoreEn   = en_q && (state != ABORT);
  assign SeqBusy  = (state != IDLE);
  assign RdData   = fifo_empty ? 36'h0 : fifo_mem[rd_ptr];
  assign Empty    = fifo_empty;
  assign Full     = fifo_full;
  assign Count    = count_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// tb/tb_meas_sequencer.sv - directed bench for meas_sequencer with a behavioural core model
module tb_meas_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        SeqEnable = 1'b0;
  logic [7:0]  SlotMask = 8'h00;
  logic [23:0] IntervalCycles = 24'd0;
  logic        CfgWe = 1'b0;
  logic [2:0]  CfgAddr = 3'd0;
  logic [31:0] CfgData = 32'h0;
  logic [31:0] CmdOut;
  logic        ClearOut, CoreEn;
  logic [2:0]  CoreStatus = 3'b000;
  logic [31:0] CoreResult = 32'h0;
  logic        RdEn = 1'b0;
  logic [35:0] RdData;
  logic        Empty, Full;
  logic [3:0]  Count;
  logic        Overflow, TimeoutSticky;
  logic        StickyClear = 1'b0;
  logic        SeqBusy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int meas_num = 0;
  int delay = 20;
  bit hang_next = 1'b0;
  int          cmd_cyc[$];
  logic [31:0] cmd_val[$];
  int          clr_cyc[$];
  int          en_low_cyc[$];

  meas_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(50), .INTERVAL_W(24)) dut (
    .Clk(Clk), .Reset(Reset), .SeqEnable(SeqEnable), .SlotMask(SlotMask),
    .IntervalCycles(IntervalCycles), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
    .CmdOut(CmdOut), .ClearOut(ClearOut), .CoreEn(CoreEn), .CoreStatus(CoreStatus),
    .CoreResult(CoreResult), .RdEn(RdEn), .RdData(RdData), .Empty(Empty), .Full(Full),
    .Count(Count), .Overflow(Overflow), .TimeoutSticky(TimeoutSticky),
    .StickyClear(StickyClear), .SeqBusy(SeqBusy)
  );

  always #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Core: done `delay` cycles after a command, result tagged by launch order
  initial begin : core_model
    int cnt;
    bit busy;
    bit hang;
    cnt = 0;
    busy = 1'b0;
    hang = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset || !CoreEn || ClearOut) begin
        CoreStatus = 3'b000;
        busy = 1'b0;
      end else if (CmdOut != 32'h0) begin
        meas_num++;
        busy = 1'b1;
        hang = hang_next;
        hang_next = 1'b0;
        cnt = delay;
        CoreStatus = 3'b100;
      end else if (busy && !hang) begin
        cnt--;
        if (cnt == 0) begin
          CoreStatus = 3'b001;
          CoreResult = 32'h1234_2000 + 32'(meas_num);
          busy = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (!Reset) begin
      if (CmdOut != 32'h0) begin
        cmd_cyc.push_back(cyc);
        cmd_val.push_back(CmdOut);
      end
      if (ClearOut) clr_cyc.push_back(cyc);
      if (!CoreEn) en_low_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] entry(input logic [2:0] s, input logic to, input int n);
    return {s, to, to ? 32'h0 : 32'h1234_2000 + 32'(n)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_logs();
    cmd_cyc.delete();
    cmd_val.delete();
    clr_cyc.delete();
    en_low_cyc.delete();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    CfgWe = 1'b1;
    CfgAddr = a;
    CfgData = d;
    tick(1);
    CfgWe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (SeqBusy && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_idle", 64'(SeqBusy), 64'(0));
  endtask

  task automatic wait_count(input int target, input int budget);
    int n;
    n = 0;
    while (int'(Count) != target && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_count", 64'(Count), 64'(target));
  endtask

  task automatic wait_cmd(input int budget);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (CmdOut == 32'h0 && n < budget);
    check("wait_cmd", 64'(CmdOut != 32'h0), 64'(1));
  endtask

  task automatic pop_check(input string tag, input logic [35:0] exp);
    check(tag, 64'(RdData), 64'(exp));
    RdEn = 1'b1;
    tick(1);
    RdEn = 1'b0;
  endtask

  initial begin
    int base;
    tick(2);
    check("rst_coreen", 64'(CoreEn), 64'(0));
    check("rst_cmd", 64'(CmdOut), 64'(0));
    check("rst_empty", 64'(Empty), 64'(1));
    check("rst_count", 64'(Count), 64'(0));
    check("rst_busy", 64'(SeqBusy), 64'(0));
    Reset = 1'b0;
    tick(1);
    check("coreen_release", 64'(CoreEn), 64'(1));

    // single slot
    cfg_write(3'd1, 32'h0810_0000);
    cfg_write(3'd7, 32'h0870_0000);
    clear_logs();
    base = meas_num;
    delay = 20;
    IntervalCycles = 24'd5000;
    SlotMask = 8'h02;
    SeqEnable = 1'b1;
    wait_count(1, 100);
    SeqEnable = 1'b0;
    wait_idle(100);
    tick(5);
    check("single_cmd_pulses", 64'(cmd_cyc.size()), 64'(1));
    check("single_cmd_val", 64'(cmd_val[0]), 64'(32'h0810_0000));
    check("single_clear_pulses", 64'(clr_cyc.size()), 64'(1));
    check("single_count", 64'(Count), 64'(1));
    pop_check("single_entry", entry(3'd1, 1'b0, base + 1));
    check("single_empty", 64'(Empty), 64'(1));

    // round robin with skipped zero slot and inter-sweep interval
    clear_logs();
    base = meas_num;
    IntervalCycles = 24'd100;
    SlotMask = 8'h8A;
    SeqEnable = 1'b1;
    wait_cmd(300);
    wait_cmd(300);
    wait_cmd(300);
    SeqEnable = 1'b0;
    wait_idle(100);
    tick(30);
    check("rr_cmd_pulses", 64'(cmd_cyc.size()), 64'(3));
    check("rr_val0", 64'(cmd_val[0]), 64'(32'h0810_0000));
    check("rr_val1", 64'(cmd_val[1]), 64'(32'h0870_0000));
    check("rr_val2", 64'(cmd_val[2]), 64'(32'h0810_0000));
    check("rr_skip_gap", 64'(cmd_cyc[1]), 64'(clr_cyc[0] + 3));
    check("rr_interval_gap", 64'(cmd_cyc[2]), 64'(clr_cyc[1] + 102));
    pop_check("rr_entry0", entry(3'd1, 1'b0, base + 1));
    pop_check("rr_entry1", entry(3'd7, 1'b0, base + 2));
    pop_check("rr_entry2", entry(3'd1, 1'b0, base + 3));

    // watchdog abort, then the next slot runs normally
    clear_logs();
    base = meas_num;
    hang_next = 1'b1;
    IntervalCycles = 24'd5000;
    SlotMask = 8'h82;
    SeqEnable = 1'b1;
    wait_count(2, 300);
    SeqEnable = 1'b0;
    wait_idle(100);
    check("to_cmd_pulses", 64'(cmd_cyc.size()), 64'(2));
    check("to_en_low_cycles", 64'(en_low_cyc.size()), 64'(1));
    check("to_en_low_at", 64'(en_low_cyc[0]), 64'(cmd_cyc[0] + 51));
    check("to_next_issue_at", 64'(cmd_cyc[1]), 64'(cmd_cyc[0] + 53));
    check("to_next_val", 64'(cmd_val[1]), 64'(32'h0870_0000));
    check("to_sticky", 64'(TimeoutSticky), 64'(1));
    pop_check("to_entry0", entry(3'd1, 1'b1, 0));
    pop_check("to_entry1", entry(3'd7, 1'b0, base + 2));
    StickyClear = 1'b1;
    tick(1);
    StickyClear = 1'b0;
    check("to_sticky_clr", 64'(TimeoutSticky), 64'(0));

    // done on the final watchdog cycle wins
    clear_logs();
    base = meas_num;
    delay = 50;
    SlotMask = 8'h02;
    SeqEnable = 1'b1;
    wait_count(1, 200);
    SeqEnable = 1'b0;
    wait_idle(100);
    check("tie_en_low", 64'(en_low_cyc.size()), 64'(0));
    check("tie_sticky", 64'(TimeoutSticky), 64'(0));
    check("tie_clear", 64'(clr_cyc.size()), 64'(1));
    pop_check("tie_entry", entry(3'd1, 1'b0, base + 1));

    // overflow, then push and pop together at full
    base = meas_num;
    delay = 3;
    IntervalCycles = 24'd0;
    SeqEnable = 1'b1;
    for (int i = 0; i < 9; i++) wait_cmd(100);
    SeqEnable = 1'b0;
    wait_idle(50);
    check("ovf_count", 64'(Count), 64'(8));
    check("ovf_full", 64'(Full), 64'(1));
    check("ovf_flag", 64'(Overflow), 64'(1));
    StickyClear = 1'b1;
    tick(1);
    StickyClear = 1'b0;
    check("ovf_clr", 64'(Overflow), 64'(0));
    SeqEnable = 1'b1;
    wait_cmd(100);
    SeqEnable = 1'b0;
    check("ovf_head", 64'(RdData), 64'(entry(3'd1, 1'b0, base + 1)));
    tick(3);
    RdEn = 1'b1;
    tick(1);
    RdEn = 1'b0;
    wait_idle(50);
    check("full_rw_count", 64'(Count), 64'(8));
    check("full_rw_no_ovf", 64'(Overflow), 64'(0));
    for (int i = 0; i < 7; i++) pop_check("ovf_entry", entry(3'd1, 1'b0, base + 2 + i));
    pop_check("ovf_last", entry(3'd1, 1'b0, base + 10));
    check("drain_empty", 64'(Empty), 64'(1));
    RdEn = 1'b1;
    tick(1);
    RdEn = 1'b0;
    check("empty_pop_count", 64'(Count), 64'(0));

    // asynchronous reset in the middle of a measurement
    delay = 40;
    SeqEnable = 1'b1;
    wait_cmd(100);
    wait_cmd(100);
    tick(5);
    check("pre_rst_count", 64'(Count), 64'(1));
    #2 Reset = 1'b1;
    #1;
    check("arst_busy", 64'(SeqBusy), 64'(0));
    check("arst_coreen", 64'(CoreEn), 64'(0));
    check("arst_count", 64'(Count), 64'(0));
    check("arst_empty", 64'(Empty), 64'(1));
    check("arst_rddata", 64'(RdData), 64'(0));
    SeqEnable = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
